// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared constants and types for the UART receive path.
//   OVERSAMPLE          oversample ticks per bit
//   SAMPLE_A/B/C        oversample ticks at which the line is sampled (C decides)
//   rx_state_e          receiver FSM state encoding
//   maj3()              2-of-3 majority vote
// The same constants are intended for reuse by the transmit side.
package uart_rx_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int OS_W       = $clog2(OVERSAMPLE);
    localparam int SAMPLE_A   = 7;
    localparam int SAMPLE_B   = 8;
    localparam int SAMPLE_C   = 9;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_baud_tick.sv
// uart_rx_baud_tick: oversample tick generator.
//   clk    system clock
//   rst    synchronous active-high reset
//   clr    synchronous clear; realigns the tick phase to a frame start
//   tick   one-cycle pulse every CLK_DIV clocks (count == CLK_DIV-1)
module uart_rx_baud_tick #(
    parameter int CLK_DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 16x oversampling and majority-vote sampling.
//   CLK        system clock, rising edge
//   RESET      synchronous active-high reset
//   RXD        asynchronous serial input, idle high
//   DATA       received byte, stable while VALID=1
//   VALID      DATA holds an unconsumed byte
//   READY      consumer accepts DATA when VALID & READY
//   FRAME_ERR  one-cycle pulse: stop bit sampled low
//   OVERRUN    one-cycle pulse: completed byte dropped, holding register full
//   BUSY       frame reception in progress
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_DIV   = 27,
    parameter int DATA_BITS = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 RXD,
    output logic [DATA_BITS-1:0] DATA,
    output logic                 VALID,
    input  logic                 READY,
    output logic                 FRAME_ERR,
    output logic                 OVERRUN,
    output logic                 BUSY
);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    logic                 meta_q, rxs_q, rxs_dly_q;
    rx_state_e            state_q, state_d;
    logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic                 s_a_q, s_a_d, s_b_q, s_b_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

    logic tick, start_edge, decide, bit_val, deliver;

    // Tick phase restarts at the start edge so samples land mid-bit.
    assign start_edge = (state_q == ST_IDLE) && rxs_dly_q && !rxs_q;

    uart_rx_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (CLK),
        .rst  (RESET),
        .clr  (start_edge),
        .tick (tick)
    );

    assign decide  = tick && (os_cnt_q == OS_W'(SAMPLE_C)) &&
                     (state_q inside {ST_START, ST_DATA, ST_STOP});
    assign bit_val = maj3(s_a_q, s_b_q, rxs_q);

    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_idx_d = bit_idx_q;
        s_a_d     = s_a_q;
        s_b_d     = s_b_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        deliver   = 1'b0;

        if (valid_q && READY) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d   = ST_START;
                    os_cnt_d  = '0;
                    bit_idx_d = '0;
                end
            end
            ST_START, ST_DATA, ST_STOP: begin
                if (tick) begin
                    os_cnt_d = os_cnt_q + 1'b1;
                    if (os_cnt_q == OS_W'(SAMPLE_A)) s_a_d = rxs_q;
                    if (os_cnt_q == OS_W'(SAMPLE_B)) s_b_d = rxs_q;
                end
                if (decide) begin
                    case (state_q)
                        ST_START: begin
                            // A high start sample means the edge was a glitch.
                            state_d   = bit_val ? ST_IDLE : ST_DATA;
                            bit_idx_d = '0;
                        end
                        ST_DATA: begin
                            shift_d                = shift_q >> 1;
                            shift_d[DATA_BITS-1]   = bit_val;
                            if (bit_idx_q == BW'(DATA_BITS - 1)) begin
                                state_d = ST_STOP;
                            end else begin
                                bit_idx_d = bit_idx_q + 1'b1;
                            end
                        end
                        default: begin
                            // Leave mid-stop-bit so a back-to-back start edge is seen.
                            if (bit_val) begin
                                deliver = 1'b1;
                                state_d = ST_IDLE;
                            end else begin
                                ferr_d  = 1'b1;
                                state_d = ST_WAIT_HIGH;
                            end
                        end
                    endcase
                end
            end
            ST_WAIT_HIGH: begin
                if (rxs_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A same-cycle handshake frees the register for the new byte.
        if (deliver) begin
            if (!valid_q || READY) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            meta_q    <= 1'b1;
            rxs_q     <= 1'b1;
            rxs_dly_q <= 1'b1;
            state_q   <= ST_IDLE;
            os_cnt_q  <= '0;
            bit_idx_q <= '0;
            s_a_q     <= 1'b0;
            s_b_q     <= 1'b0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            meta_q    <= RXD;
            rxs_q     <= meta_q;
            rxs_dly_q <= rxs_q;
            state_q   <= state_d;
            os_cnt_q  <= os_cnt_d;
            bit_idx_q <= bit_idx_d;
            s_a_q     <= s_a_d;
            s_b_q     <= s_b_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign DATA      = data_q;
    assign VALID     = valid_q;
    assign FRAME_ERR = ferr_q;
    assign OVERRUN   = ovr_q;
    assign BUSY      = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the counterpart of the System transmit path that drives TXD.
- Receives host bytes on RXD (target hash, start/stop commands) and presents them to the search controller through a one-byte valid/ready holding register.
- Uses 16x oversampling with majority vote, and detects framing and overrun errors.
- Sits between the board RXD pin and the command decoder, in the CLK domain.

Parameters:
- CLK_DIV, 27, system clocks per oversample tick. 50 MHz / (115200 × 16) ≈ 27. Legal range ≥ 2.
- DATA_BITS, 8, payload bits per frame, LSB first.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- RXD  in  1  asynchronous serial line; idle high.
- DATA  out  DATA_BITS  received byte; stable while VALID=1.
- VALID  out  1  DATA holds an unconsumed byte.
- READY  in  1  consumer accepts DATA on a cycle where VALID=1 and READY=1.
- FRAME_ERR  out  1  one-cycle pulse: stop bit sampled 0.
- OVERRUN  out  1  one-cycle pulse: completed byte dropped because the holding register was full.
- BUSY  out  1  frame reception in progress (state ≠ IDLE).

Behaviour:
- Reset: DATA=0, VALID=0, FRAME_ERR=0, OVERRUN=0, BUSY=0.
  - Both RXD synchronizer flops = 1, state=IDLE, all counters=0.
- Synchronizer: 2-FF synchronizer on RXD gives rxs. A third flop rxs_d is used for falling-edge detection.
- Tick generator:
  - Counter 0..CLK_DIV-1; tick is a one-cycle pulse when count==CLK_DIV-1.
  - Forced to 0 on start-edge detection so ticks are frame-aligned.
- Bit sampling:
  - Per-bit oversample counter 0..15.
  - rxs is captured at ticks 7, 8 and 9; bit value = majority of the three.
  - The decision is made on tick 9.
- FSM: IDLE → START → DATA → STOP → IDLE, plus WAIT_HIGH.
  - IDLE: rxs_d=1 and rxs=0 → START. A line held low out of reset does not start a frame; a falling edge is required.
  - START: at the tick-9 decision, value 1 is a glitch → IDLE with no outputs. Value 0 → DATA, bit index=0.
  - DATA: at each tick-9 decision, shift the value in LSB-first. After DATA_BITS bits → STOP.
  - STOP:
    - Value 1 → deliver the byte and go to IDLE. IDLE is entered mid-stop-bit so a back-to-back start edge is caught.
    - Value 0 → FRAME_ERR pulse, byte discarded, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs=1, then IDLE. This covers a break or held-low line.
- Delivery, registered on the edge after the stop decision:
  - VALID=0: load DATA, VALID=1.
  - VALID=1 and READY=1 on the same cycle: old byte consumed, new byte loaded, VALID stays 1, no OVERRUN.
  - VALID=1 and READY=0: new byte dropped, DATA unchanged, OVERRUN pulse.
- Handshake:
  - VALID=1 and READY=1 with no delivery that cycle → VALID=0 on the next edge.
  - DATA never changes while VALID=1 unless a handshake occurs on that cycle.
- Latency: VALID rises 1 clock after the stop-bit tick-9 decision, about 9.5 bit times after the start edge.
- Reset mid-frame: everything returns to reset values immediately and the partial byte is lost. Reception resumes on the next falling edge.
- FRAME_ERR and OVERRUN are mutually exclusive per frame.

Decomposition:
- Shared include file uart_defs.vh holds:
  - OVERSAMPLE=16 and the sample-tick constants 7/8/9.
  - FSM state encodings (IDLE, START, DATA, STOP, WAIT_HIGH).
  - This file is reused by the TX side.
- One natural sub-module: uart_baud_tick (CLK_DIV counter with sync clear, tick output), shareable with the transmitter.

Test Plan (CLK_DIV=4, so 64 clocks per bit):
- Send 0x55 with READY=1 → VALID=1 with DATA=0x55 about 608 clocks after the start edge. VALID=0 the following cycle; FRAME_ERR=0, OVERRUN=0.
- RXD low for 20 clocks then high → no VALID, no FRAME_ERR, BUSY returns to 0 within 40 clocks. Then send 0x81 → DATA=0x81.
- Send 0xA3 with stop bit 0, hold RXD low 300 clocks, release, then send 0x3C.
  - Expected: one FRAME_ERR pulse and no VALID for 0xA3.
  - Then VALID with DATA=0x3C.
- READY=0; send 0x11, then 0x22 back-to-back.
  - Expected: DATA=0x11 throughout and one OVERRUN pulse at the second stop.
  - Then raise READY → 0x11 accepted, VALID=0.
  - Repeat with READY pulsed on the exact delivery cycle → DATA=0x22, no OVERRUN.
- Send 0x00 with RXD forced high for clocks 32–35 of bit 3 (the tick-8 sample) → majority yields DATA=0x00.
- Assert RESET for 1 cycle during bit 4 of 0xFF → all outputs reset values, no byte delivered from the partial frame. The next 0x81 is received correctly.
